// File: rtl/stage_1_pkg.sv
// Shared constants and types for the instruction-fetch stage (stage_1).
package stage_1_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

  typedef enum logic [0:0] {
    FETCH_REQ  = 1'b0,
    FETCH_FULL = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/stage_1_fetch_skid.sv
// One-entry {inst, pc} holding buffer used when a fetch completes during a stall.
import stage_1_pkg::*;

module fetch_skid (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         valid
);

  // Entry storage; clear wins over load so a flush never leaves stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      dout  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      dout  <= din;
      valid <= 1'b1;
    end else begin
      dout  <= dout;
      valid <= valid;
    end
  end

endmodule

// File: rtl/stage_1.sv
// Instruction-fetch stage with IF/ID pipeline register, req/ack memory
// handshake, branch redirect/flush, stall hold and a one-entry skid buffer.
import stage_1_pkg::*;

module stage_1 #(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        b_taken,
  input  logic [31:0] b_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_inst,
  output logic [31:0] pc,
  output logic        if_id_valid,
  output logic        misalign
);

  fetch_state_e state_r;
  fetch_state_e next_state_s;

  logic [31:0]  fetch_pc_r;
  logic [31:0]  fetch_pc_nxt_s;
  logic [31:0]  pc_inc_s;
  logic [31:0]  inst_nxt_s;
  logic [31:0]  pc_nxt_s;
  logic         valid_nxt_s;
  logic         misalign_nxt_s;
  logic         redirect_s;
  logic         skid_load_s;
  logic         skid_clear_s;
  logic         skid_valid_s;
  fetch_entry_t skid_din_s;
  fetch_entry_t skid_dout_s;

  assign redirect_s = b_taken & ~stall;
  assign pc_inc_s   = fetch_pc_r + 32'd4;
  assign skid_din_s = '{inst: imem_rdata, pc: fetch_pc_r};

  fetch_skid u_skid (
    .clk   (clk),
    .rst   (rst),
    .load  (skid_load_s),
    .clear (skid_clear_s),
    .din   (skid_din_s),
    .dout  (skid_dout_s),
    .valid (skid_valid_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH_REQ;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and next-datapath decode; redirect outranks any ack or skid drain.
  always_comb begin
    next_state_s   = state_r;
    fetch_pc_nxt_s = fetch_pc_r;
    inst_nxt_s     = if_id_inst;
    pc_nxt_s       = pc;
    valid_nxt_s    = if_id_valid;
    misalign_nxt_s = 1'b0;
    skid_load_s    = 1'b0;
    skid_clear_s   = 1'b0;
    case (state_r)
      FETCH_REQ: begin
        if (redirect_s) begin
          fetch_pc_nxt_s = word_align(b_pc);
          inst_nxt_s     = NOP_INST;
          valid_nxt_s    = 1'b0;
          misalign_nxt_s = |b_pc[1:0];
        end else if (imem_ack && !stall) begin
          inst_nxt_s     = imem_rdata;
          pc_nxt_s       = fetch_pc_r;
          valid_nxt_s    = 1'b1;
          fetch_pc_nxt_s = pc_inc_s;
        end else if (imem_ack && stall) begin
          skid_load_s    = 1'b1;
          fetch_pc_nxt_s = pc_inc_s;
          next_state_s   = FETCH_FULL;
        end else if (!stall) begin
          inst_nxt_s  = NOP_INST;
          valid_nxt_s = 1'b0;
        end else begin
          next_state_s = FETCH_REQ;
        end
      end
      FETCH_FULL: begin
        if (stall) begin
          next_state_s = FETCH_FULL;
        end else if (b_taken) begin
          skid_clear_s   = 1'b1;
          inst_nxt_s     = NOP_INST;
          valid_nxt_s    = 1'b0;
          fetch_pc_nxt_s = word_align(b_pc);
          misalign_nxt_s = |b_pc[1:0];
          next_state_s   = FETCH_REQ;
        end else if (skid_valid_s) begin
          inst_nxt_s   = skid_dout_s.inst;
          pc_nxt_s     = skid_dout_s.pc;
          valid_nxt_s  = 1'b1;
          skid_clear_s = 1'b1;
          next_state_s = FETCH_REQ;
        end else begin
          inst_nxt_s   = NOP_INST;
          valid_nxt_s  = 1'b0;
          next_state_s = FETCH_REQ;
        end
      end
      default: begin
        next_state_s = FETCH_REQ;
      end
    endcase
  end

  // Memory request outputs: the only combinational outputs of the stage.
  always_comb begin
    if (state_r == FETCH_REQ) begin
      imem_req = 1'b1;
    end else begin
      imem_req = 1'b0;
    end
    imem_addr = fetch_pc_r;
  end

  // Fetch PC and IF/ID pipeline register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r  <= RESET_PC;
      if_id_inst  <= NOP_INST;
      pc          <= RESET_PC;
      if_id_valid <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      fetch_pc_r  <= fetch_pc_nxt_s;
      if_id_inst  <= inst_nxt_s;
      pc          <= pc_nxt_s;
      if_id_valid <= valid_nxt_s;
      misalign    <= misalign_nxt_s;
    end
  end

endmodule

// File: tb/tb_stage_1.sv
// Self-checking bench for stage_1: directed vector table, corner sequences
// and randomized traffic against a queue-based reference model.
module tb_stage_1;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        b_taken = 1'b0;
  logic [31:0] b_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_inst;
  logic [31:0] pc;
  logic        if_id_valid;
  logic        misalign;

  int vectors = 0;
  int miscompares = 0;

  stage_1 dut (
    .clk(clk), .rst(rst), .stall(stall), .b_taken(b_taken), .b_pc(b_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_id_inst(if_id_inst), .pc(pc),
    .if_id_valid(if_id_valid), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Memory contents: each word is the bitwise complement of its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a;
  endfunction
  assign imem_rdata = mem_word(imem_addr);

  typedef struct {
    logic        st;
    logic        bt;
    logic [31:0] bp;
    logic        ack;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
    logic        mis;
  } vec_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } ent_t;

  // Reference model state.
  logic [31:0] m_fpc;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_mis;
  ent_t        m_skid[$];

  vec_t tbl[15];
  vec_t none;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fpc = 32'h0; m_inst = NOP; m_pc = 32'h0; m_valid = 1'b0; m_mis = 1'b0;
    m_skid.delete();
  endtask

  // One clock of the stage described directly from its behavioural rules.
  task automatic model_step(input logic s, input logic bt, input logic [31:0] bp, input logic a);
    ent_t e;
    m_mis = 1'b0;
    if (m_skid.size() == 0) begin
      if (bt && !s) begin
        m_fpc = bp & 32'hFFFF_FFFC; m_inst = NOP; m_valid = 1'b0; m_mis = (bp[1:0] != 2'b00);
      end else if (a && !s) begin
        m_inst = mem_word(m_fpc); m_pc = m_fpc; m_valid = 1'b1; m_fpc = m_fpc + 32'd4;
      end else if (a) begin
        e.inst = mem_word(m_fpc); e.pc = m_fpc; m_skid.push_back(e); m_fpc = m_fpc + 32'd4;
      end else if (!s) begin
        m_inst = NOP; m_valid = 1'b0;
      end
    end else if (!s) begin
      if (bt) begin
        m_skid.delete();
        m_inst = NOP; m_valid = 1'b0; m_fpc = bp & 32'hFFFF_FFFC; m_mis = (bp[1:0] != 2'b00);
      end else begin
        e = m_skid.pop_front();
        m_inst = e.inst; m_pc = e.pc; m_valid = 1'b1;
      end
    end
  endtask

  // Drive one cycle; compare against the table record or the model.
  task automatic step(input logic s, input logic bt, input logic [31:0] bp, input logic a,
                      input bit use_tbl, input vec_t e);
    logic        x_req, x_valid, x_mis;
    logic [31:0] x_addr, x_inst, x_pc;
    stall = s; b_taken = bt; b_pc = bp; imem_ack = a;
    #1;
    x_req  = use_tbl ? e.req  : (m_skid.size() == 0);
    x_addr = use_tbl ? e.addr : m_fpc;
    chk("imem_req", {31'h0, imem_req}, {31'h0, x_req});
    chk("imem_addr", imem_addr, x_addr);
    @(posedge clk);
    model_step(s, bt, bp, a);
    #1;
    x_inst  = use_tbl ? e.inst  : m_inst;
    x_pc    = use_tbl ? e.pc    : m_pc;
    x_valid = use_tbl ? e.valid : m_valid;
    x_mis   = use_tbl ? e.mis   : m_mis;
    chk("if_id_inst", if_id_inst, x_inst);
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, x_valid});
    chk("misalign", {31'h0, misalign}, {31'h0, x_mis});
    if (x_valid) chk("pc", pc, x_pc);
    @(negedge clk);
  endtask

  task automatic chk_reset_values();
    chk("rst imem_req", {31'h0, imem_req}, 32'h1);
    chk("rst imem_addr", imem_addr, 32'h0);
    chk("rst if_id_inst", if_id_inst, NOP);
    chk("rst pc", pc, 32'h0);
    chk("rst if_id_valid", {31'h0, if_id_valid}, 32'h0);
    chk("rst misalign", {31'h0, misalign}, 32'h0);
  endtask

  initial begin
    //            st    bt    bp            ack   req   addr          inst          pc            valid mis
    tbl[0]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0004, 32'hFFFF_FFFB, 32'h0000_0004, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0008, NOP,           32'h0000_0004, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0008, 32'hFFFF_FFF7, 32'h0000_0008, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_000C, 32'hFFFF_FFF7, 32'h0000_0008, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_0010, 32'hFFFF_FFF7, 32'h0000_0008, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_0010, 32'hFFFF_FFF3, 32'h0000_000C, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFEF, 32'h0000_0010, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 32'h100,     1'b1, 1'b1, 32'h0000_0014, NOP,           32'h0000_0010, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 32'h200,     1'b0, 1'b1, 32'h0000_0100, NOP,           32'h0000_0010, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 32'h102,     1'b0, 1'b1, 32'h0000_0100, NOP,           32'h0000_0010, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0100, 32'hFFFF_FEFF, 32'h0000_0100, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0104, 32'hFFFF_FEFF, 32'h0000_0100, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 32'h203,     1'b1, 1'b0, 32'h0000_0108, NOP,           32'h0000_0100, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0200, 32'hFFFF_FDFF, 32'h0000_0200, 1'b1, 1'b0};
    none = tbl[0];

    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_values();
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].st, tbl[i].bt, tbl[i].bp, tbl[i].ack, 1'b1, tbl[i]);
    end

    // Wrap: fetch at 0xFFFF_FFFC, next address is 0.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, none);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, none);
    chk("wrap inst", if_id_inst, 32'h0000_0003);
    chk("wrap pc", pc, 32'hFFFF_FFFC);
    chk("wrap next addr", imem_addr, 32'h0);

    // Ack every third cycle.
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 32'h0, (i % 3 == 2), 1'b0, none);
    end

    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) == 0, ($urandom % 8) == 0, $urandom, ($urandom % 3) != 0, 1'b0, none);
    end

    // Asynchronous reset in the middle of a request with misalign high.
    step(1'b0, 1'b1, 32'h0000_0801, 1'b0, 1'b0, none);
    stall = 1'b0; b_taken = 1'b0; imem_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_reset_values();
    model_reset();
    @(negedge clk);
    imem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    imem_ack = 1'b0;
    #1;
    chk_reset_values();
    @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      step(($urandom % 4) == 0, ($urandom % 8) == 0, $urandom, ($urandom % 3) != 0, 1'b0, none);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
